// File: rtl/regfile_wb_ctrl_if.sv
// Writeback bus for regfile_wb_ctrl: two requester
// handshakes plus the register-file write port.
interface regfile_wb_ctrl_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          req0_valid;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_data;
    logic          req0_ready;
    logic          req1_valid;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_data;
    logic          req1_ready;
    logic          we3;
    logic [AW-1:0] wa3;
    logic [DW-1:0] wd3;
    logic          init_done;

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output we3, wa3, wd3, init_done
    );

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  we3, wa3, wd3, init_done
    );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port controller: zero-init sweep after reset,
// then round-robin sharing of the write port between two writers.
module regfile_wb_ctrl #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int NREG = 32
) (
    input  logic              clk,
    input  logic              reset,
    regfile_wb_ctrl_if.slave  bus
);
    typedef enum logic {INIT, RUN} state_t;

    localparam logic [AW-1:0] LAST = AW'(NREG - 1);

    state_t        r_state, w_state_nx;
    logic [AW-1:0] r_cnt, w_cnt_nx;
    logic          r_last, w_last_nx;
    logic          r_we3, w_we3_nx;
    logic [AW-1:0] r_wa3, w_wa3_nx;
    logic [DW-1:0] r_wd3, w_wd3_nx;
    logic          r_done, w_done_nx;

    logic w_g0, w_g1, w_rdy0, w_rdy1;

    // r_last names the previous winner; on a tie the other side wins
    assign w_g0 = bus.req0_valid & (~bus.req1_valid | r_last);
    assign w_g1 = bus.req1_valid & (~bus.req0_valid | ~r_last);

    assign w_rdy0 = (r_state == RUN) & w_g0;
    assign w_rdy1 = (r_state == RUN) & w_g1;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_last_nx  = r_last;
        w_we3_nx   = r_we3;
        w_wa3_nx   = r_wa3;
        w_wd3_nx   = r_wd3;
        w_done_nx  = r_done;
        unique case (r_state)
            INIT: begin
                w_we3_nx = 1'b1;
                w_wa3_nx = r_cnt;
                w_wd3_nx = '0;
                if (r_cnt == LAST) begin
                    w_state_nx = RUN;
                    w_done_nx  = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            RUN: begin
                if (w_rdy0) begin
                    w_last_nx = 1'b0;
                    w_wa3_nx  = bus.req0_addr;
                    w_wd3_nx  = bus.req0_data;
                    w_we3_nx  = (bus.req0_addr != '0);
                end else if (w_rdy1) begin
                    w_last_nx = 1'b1;
                    w_wa3_nx  = bus.req1_addr;
                    w_wd3_nx  = bus.req1_data;
                    w_we3_nx  = (bus.req1_addr != '0);
                end else begin
                    w_we3_nx = 1'b0;
                end
            end
            default: w_state_nx = INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= INIT;
            r_cnt   <= AW'(1);
            r_last  <= 1'b1;
            r_we3   <= 1'b0;
            r_wa3   <= '0;
            r_wd3   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_last  <= w_last_nx;
            r_we3   <= w_we3_nx;
            r_wa3   <= w_wa3_nx;
            r_wd3   <= w_wd3_nx;
            r_done  <= w_done_nx;
        end
    end

    assign bus.req0_ready = w_rdy0;
    assign bus.req1_ready = w_rdy1;
    assign bus.we3        = r_we3;
    assign bus.wa3        = r_wa3;
    assign bus.wd3        = r_wd3;
    assign bus.init_done  = r_done;
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: vector table for RUN
// arbitration, hand sequences for init sweep and resets.
module tb_regfile_wb_ctrl;
    logic clk;
    logic reset;

    regfile_wb_ctrl_if #(.DW(32), .AW(5)) bus ();

    regfile_wb_ctrl #(.DW(32), .AW(5), .NREG(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } exp_t;

    typedef struct {
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        r0;
        logic        r1;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } vec_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    task automatic drive(input logic v0, input logic [4:0] a0,
                         input logic [31:0] d0, input logic v1,
                         input logic [4:0] a1, input logic [31:0] d1);
        bus.req0_valid = v0;
        bus.req0_addr  = a0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_addr  = a1;
        bus.req1_data  = d1;
    endtask

    // Called at posedge+1 with inputs already driven.
    task automatic cyc(input string nm, input logic er0,
                       input logic er1, input exp_t e);
        exp_t got;
        #2;
        chk({nm, " rdy0"}, 32'(bus.req0_ready), 32'(er0));
        chk({nm, " rdy1"}, 32'(bus.req1_ready), 32'(er1));
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk({nm, " queue"}, 32'(0), 32'(1));
        end else begin
            got = q.pop_front();
            chk({nm, " we3"}, 32'(bus.we3), 32'(got.we));
            chk({nm, " wa3"}, 32'(bus.wa3), 32'(got.wa));
            chk({nm, " wd3"}, bus.wd3, got.wd);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst we3", 32'(bus.we3), 32'(0));
        chk("rst wa3", 32'(bus.wa3), 32'(0));
        chk("rst wd3", bus.wd3, 32'(0));
        chk("rst done", 32'(bus.init_done), 32'(0));
        chk("rst rdy0", 32'(bus.req0_ready), 32'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic sweep();
        exp_t e;
        for (int k = 1; k <= 31; k++) begin
            e.we = 1'b1;
            e.wa = 5'(k);
            e.wd = 32'h0;
            cyc($sformatf("init%0d", k), 1'b0, 1'b0, e);
            chk($sformatf("init%0d done", k), 32'(bus.init_done),
                32'(k == 31));
        end
    endtask

    vec_t vt[13];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);

        vt[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 31, 32'h0};
        vt[1]  = '{1, 3, 32'h11, 1, 4, 32'h22, 1, 0, 1, 3, 32'h11};
        vt[2]  = '{1, 3, 32'h11, 1, 4, 32'h22, 0, 1, 1, 4, 32'h22};
        vt[3]  = '{1, 3, 32'h11, 1, 4, 32'h22, 1, 0, 1, 3, 32'h11};
        vt[4]  = '{1, 3, 32'h11, 1, 4, 32'h22, 0, 1, 1, 4, 32'h22};
        vt[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 32'h22};
        vt[6]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 0, 1, 5, 32'hDEADBEEF};
        vt[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 32'hDEADBEEF};
        vt[8]  = '{0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 1, 0, 0, 32'hFFFFFFFF};
        vt[9]  = '{1, 3, 32'h11, 1, 4, 32'h22, 1, 0, 1, 3, 32'h11};
        vt[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 32'h11};
        vt[11] = '{0, 0, 0, 1, 7, 32'hA5A5, 0, 1, 1, 7, 32'hA5A5};
        vt[12] = '{0, 0, 0, 1, 8, 32'h5A, 0, 1, 1, 8, 32'h5A};

        #1;
        do_reset();
        sweep();
        e = '{1'b0, 5'd31, 32'h0};
        cyc("post-init idle", 1'b0, 1'b0, e);

        foreach (vt[i]) begin
            drive(vt[i].v0, vt[i].a0, vt[i].d0,
                  vt[i].v1, vt[i].a1, vt[i].d1);
            e = '{vt[i].we, vt[i].wa, vt[i].wd};
            cyc($sformatf("vec%0d", i), vt[i].r0, vt[i].r1, e);
        end
        drive(0, 0, 0, 0, 0, 0);

        // req0 waits through the whole sweep
        drive(1, 9, 32'h99, 0, 0, 0);
        do_reset();
        sweep();
        e = '{1'b1, 5'd9, 32'h99};
        cyc("init-req accept", 1'b1, 1'b0, e);
        drive(0, 0, 0, 0, 0, 0);
        e = '{1'b0, 5'd9, 32'h99};
        cyc("init-req after", 1'b0, 1'b0, e);

        // asynchronous reset in the middle of the sweep
        do_reset();
        for (int k = 1; k <= 10; k++) @(posedge clk);
        #1;
        chk("mid pre wa3", 32'(bus.wa3), 32'(10));
        reset = 1'b1;
        #1;
        chk("mid we3", 32'(bus.we3), 32'(0));
        chk("mid wa3", 32'(bus.wa3), 32'(0));
        chk("mid done", 32'(bus.init_done), 32'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        e = '{1'b1, 5'd1, 32'h0};
        cyc("restart", 1'b0, 1'b0, e);
        e = '{1'b1, 5'd2, 32'h0};
        cyc("restart2", 1'b0, 1'b0, e);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
